// File: rtl/mips_bp_pkg.sv
// ---------------------------------------------------------------------------------------------
// mips_bp_pkg
// Shared definitions for the branch history/target table predictor:
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - counter values used at reset and on allocation
//   - default index/PC widths and helpers for the derived tag width
// ---------------------------------------------------------------------------------------------
package mips_bp_pkg;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } bp_ctr_e;

    // Counter value of every entry after reset, and of a freshly allocated entry.
    localparam bp_ctr_e CtrReset = CtrWnt;
    localparam bp_ctr_e CtrAlloc = CtrWt;

    localparam int unsigned DefaultIndexBits = 4;
    localparam int unsigned DefaultPcWidth   = 32;
    localparam int unsigned InstrBytes       = 4;
    // PC[1:0] are always zero for word-aligned MIPS instructions and are not stored.
    localparam int unsigned PcOffsetBits     = 2;

    function automatic int unsigned tag_bits(int unsigned pc_width, int unsigned index_bits);
        return pc_width - index_bits - PcOffsetBits;
    endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// ---------------------------------------------------------------------------------------------
// bp_sat_counter2
// Next-state logic of a 2-bit saturating branch counter (purely combinational).
// Ports:
//   taken_i  in   resolved branch outcome
//   ctr_i    in   current counter state
//   ctr_o    out  counter state after stepping (+1 taken, -1 not taken, saturating)
// ---------------------------------------------------------------------------------------------
module bp_sat_counter2
    import mips_bp_pkg::*;
(
    input  logic    taken_i,
    input  bp_ctr_e ctr_i,
    output bp_ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            CtrSnt: ctr_o = taken_i ? CtrWnt : CtrSnt;
            CtrWnt: ctr_o = taken_i ? CtrWt  : CtrSnt;
            CtrWt:  ctr_o = taken_i ? CtrSt  : CtrWnt;
            CtrSt:  ctr_o = taken_i ? CtrSt  : CtrWt;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------------------------
// branch_predictor_bht
// Direct-mapped branch history/target table for the 5-stage MIPS pipeline. Looked up
// combinationally with the IF PC, trained by branches resolving in EX. A misprediction
// produces a redirect plus IF/ID and ID/EX flushes that override the load-use stall.
//
// Ports:
//   CLK, RESET_N                      clock, asynchronous active-low reset
//   PC_IF                             IF-stage lookup PC
//   IsBranch_EX, BranchTaken_EX       EX branch valid / actual outcome
//   PC_EX, Target_EX                  EX branch PC / computed target
//   PredTaken_EX, PredTarget_EX       prediction carried down the pipe with the EX branch
//   BranchPredictSel, PredTarget      IF prediction (taken / target)
//   Redirect, RedirectPC              mispredict correction
//   Flush_IFID, Flush_IDEX            squash requests on mispredict
//
// Configuration:
//   BP_PERF_COUNTERS_EN  adds BranchCount / MispredictCount (32-bit, saturating).
// ---------------------------------------------------------------------------------------------
module branch_predictor_bht
    import mips_bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DefaultIndexBits,
    parameter int unsigned PC_WIDTH   = DefaultPcWidth
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [PC_WIDTH-1:0] PC_IF,
    input  logic                IsBranch_EX,
    input  logic                BranchTaken_EX,
    input  logic [PC_WIDTH-1:0] PC_EX,
    input  logic [PC_WIDTH-1:0] Target_EX,
    input  logic                PredTaken_EX,
    input  logic [PC_WIDTH-1:0] PredTarget_EX,
    output logic                BranchPredictSel,
    output logic [PC_WIDTH-1:0] PredTarget,
    output logic                Redirect,
    output logic [PC_WIDTH-1:0] RedirectPC,
    output logic                Flush_IFID,
    output logic                Flush_IDEX
`ifdef BP_PERF_COUNTERS_EN
    ,
    output logic [31:0]         BranchCount,
    output logic [31:0]         MispredictCount
`endif
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam int unsigned TagBits = tag_bits(PC_WIDTH, INDEX_BITS);
    localparam int unsigned IdxLo   = PcOffsetBits;
    localparam int unsigned IdxHi   = INDEX_BITS + PcOffsetBits - 1;
    localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(InstrBytes);

    // Table storage
    logic [Entries-1:0]  valid_q;
    logic [TagBits-1:0]  tag_q    [Entries];
    bp_ctr_e             ctr_q    [Entries];
    logic [PC_WIDTH-1:0] target_q [Entries];

    // Lookup (IF)
    logic [INDEX_BITS-1:0] if_idx;
    logic [TagBits-1:0]    if_tag;
    logic                  if_hit;

    assign if_idx = PC_IF[IdxHi:IdxLo];
    assign if_tag = PC_IF[PC_WIDTH-1:IdxHi+1];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // Resolution (EX)
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TagBits-1:0]    ex_tag;
    logic                  ex_hit;
    logic                  mispredict;
    logic                  redirect;

    assign ex_idx = PC_EX[IdxHi:IdxLo];
    assign ex_tag = PC_EX[PC_WIDTH-1:IdxHi+1];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        mispredict = 1'b0;
        if (IsBranch_EX) begin
            if (PredTaken_EX != BranchTaken_EX) begin
                mispredict = 1'b1;
            end else if (BranchTaken_EX && (PredTarget_EX != Target_EX)) begin
                mispredict = 1'b1;
            end
        end
    end

    // Gating with RESET_N drops a pending mispredict as soon as reset asserts.
    assign redirect   = mispredict && RESET_N;
    assign Redirect   = redirect;
    assign Flush_IFID = redirect;
    assign Flush_IDEX = redirect;
    assign RedirectPC = !redirect       ? '0        :
                        BranchTaken_EX  ? Target_EX : (PC_EX + PcStep);

    // A redirect wins over the IF prediction for the next PC.
    assign BranchPredictSel = if_hit && ctr_q[if_idx][1] && !redirect;
    assign PredTarget       = if_hit ? target_q[if_idx] : '0;

    // Update path
    bp_ctr_e             ctr_step;
    logic                wr_en;
    bp_ctr_e             wr_ctr;
    logic [PC_WIDTH-1:0] wr_target;

    bp_sat_counter2 u_ctr (
        .taken_i (BranchTaken_EX),
        .ctr_i   (ctr_q[ex_idx]),
        .ctr_o   (ctr_step)
    );

    always_comb begin
        wr_en     = 1'b0;
        wr_ctr    = ctr_step;
        wr_target = target_q[ex_idx];
        if (IsBranch_EX) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (BranchTaken_EX) begin
                    wr_target = Target_EX;
                end
            end else if (BranchTaken_EX) begin
                // Allocation on a taken miss; not-taken misses leave the table alone.
                wr_en     = 1'b1;
                wr_ctr    = CtrAlloc;
                wr_target = Target_EX;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                tag_q[i]    <= '0;
                ctr_q[i]    <= CtrReset;
                target_q[i] <= '0;
            end
        end else if (wr_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            ctr_q[ex_idx]    <= wr_ctr;
            target_q[ex_idx] <= wr_target;
        end
    end

`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (IsBranch_EX && (branch_count_q != 32'hFFFF_FFFF)) begin
            branch_count_d = branch_count_q + 32'd1;
        end
        if (redirect && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign BranchCount     = branch_count_q;
    assign MispredictCount = mispredict_count_q;
`endif

    // Word-offset bits never participate in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_IF[IdxLo-1:0], PC_EX[IdxLo-1:0]};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------------------------
// tb_branch_predictor_bht
// Scoreboard bench: each stimulus cycle pushes the expected combinational outputs into a
// queue; a monitor on the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------------------------
module tb_branch_predictor_bht;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] PC_IF;
    logic        IsBranch_EX;
    logic        BranchTaken_EX;
    logic [31:0] PC_EX;
    logic [31:0] Target_EX;
    logic        PredTaken_EX;
    logic [31:0] PredTarget_EX;
    logic        BranchPredictSel;
    logic [31:0] PredTarget;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Flush_IFID;
    logic        Flush_IDEX;
`ifdef BP_PERF_COUNTERS_EN
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;
`endif

    always #5 CLK = ~CLK;

    branch_predictor_bht #(
        .INDEX_BITS (4),
        .PC_WIDTH   (32)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .PC_IF            (PC_IF),
        .IsBranch_EX      (IsBranch_EX),
        .BranchTaken_EX   (BranchTaken_EX),
        .PC_EX            (PC_EX),
        .Target_EX        (Target_EX),
        .PredTaken_EX     (PredTaken_EX),
        .PredTarget_EX    (PredTarget_EX),
        .BranchPredictSel (BranchPredictSel),
        .PredTarget       (PredTarget),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .Flush_IFID       (Flush_IFID),
        .Flush_IDEX       (Flush_IDEX)
`ifdef BP_PERF_COUNTERS_EN
        ,
        .BranchCount      (BranchCount),
        .MispredictCount  (MispredictCount)
`endif
    );

    typedef struct {
        string       name;
        logic        bps;
        logic [31:0] pt;
        logic        red;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] PcA  = 32'h0040_0010;
    localparam logic [31:0] PcB  = 32'h0040_0050; // same index as PcA, different tag
    localparam logic [31:0] TgtA = 32'h0040_0040;
    localparam logic [31:0] TgtB = 32'h0040_0100;
    localparam logic [31:0] PcW  = 32'hFFFF_FFFC;

    task automatic chk(input string n, input string f, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", n, f, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "BranchPredictSel", 32'(BranchPredictSel), 32'(e.bps));
            chk(e.name, "PredTarget", PredTarget, e.pt);
            chk(e.name, "Redirect", 32'(Redirect), 32'(e.red));
            chk(e.name, "RedirectPC", RedirectPC, e.rpc);
            chk(e.name, "Flush_IFID", 32'(Flush_IFID), 32'(e.red));
            chk(e.name, "Flush_IDEX", 32'(Flush_IDEX), 32'(e.red));
        end
    end

    // One cycle: drive just after the rising edge, queue the expected outputs.
    task automatic step(input string n, input logic rst, input logic [31:0] pc_if,
                        input logic isb, input logic tk, input logic [31:0] pc_ex,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                        input logic e_bps, input logic [31:0] e_pt,
                        input logic e_red, input logic [31:0] e_rpc);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET_N        = rst;
        PC_IF          = pc_if;
        IsBranch_EX    = isb;
        BranchTaken_EX = tk;
        PC_EX          = pc_ex;
        Target_EX      = tgt;
        PredTaken_EX   = ptk;
        PredTarget_EX  = ptgt;
        e.name = n;
        e.bps  = e_bps;
        e.pt   = e_pt;
        e.red  = e_red;
        e.rpc  = e_rpc;
        sb.push_back(e);
    endtask

    task automatic look(input string n, input logic rst, input logic [31:0] pc_if,
                        input logic e_bps, input logic [31:0] e_pt);
        step(n, rst, pc_if, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, e_bps, e_pt, 1'b0, 32'h0);
    endtask

    initial begin
        RESET_N        = 1'b0;
        PC_IF          = '0;
        IsBranch_EX    = 1'b0;
        BranchTaken_EX = 1'b0;
        PC_EX          = '0;
        Target_EX      = '0;
        PredTaken_EX   = 1'b0;
        PredTarget_EX  = '0;

        look("reset", 1'b0, PcA, 1'b0, 32'h0);
        look("idle",  1'b1, PcA, 1'b0, 32'h0);
        // Taken miss, predicted not-taken: redirect to target, allocate WT.
        step("alloc", 1'b1, PcA, 1'b1, 1'b1, PcA, TgtA, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, TgtA);
        look("hit_wt", 1'b1, PcA, 1'b1, TgtA);
        // Predicted taken, actually not: PC+4, prediction suppressed by redirect. WT->WNT.
        step("nt_mis", 1'b1, PcA, 1'b1, 1'b0, PcA, TgtA, 1'b1, TgtA, 1'b0, TgtA, 1'b1,
             32'h0040_0014);
        look("wnt", 1'b1, PcA, 1'b0, TgtA);
        // Taken resolutions, correctly predicted: WNT->WT->ST->ST->ST (lookup is pre-update).
        step("tk1", 1'b1, PcA, 1'b1, 1'b1, PcA, TgtA, 1'b1, TgtA, 1'b0, TgtA, 1'b0, 32'h0);
        step("tk2", 1'b1, PcA, 1'b1, 1'b1, PcA, TgtA, 1'b1, TgtA, 1'b1, TgtA, 1'b0, 32'h0);
        step("tk3", 1'b1, PcA, 1'b1, 1'b1, PcA, TgtA, 1'b1, TgtA, 1'b1, TgtA, 1'b0, 32'h0);
        // Taken with a wrong predicted target: redirect to the real target.
        step("tk4_tgt", 1'b1, PcA, 1'b1, 1'b1, PcA, TgtA, 1'b1, 32'h0040_0080, 1'b0, TgtA,
             1'b1, TgtA);
        step("tk5_sat", 1'b1, PcA, 1'b1, 1'b1, PcA, TgtA, 1'b1, TgtA, 1'b1, TgtA, 1'b0, 32'h0);
        // ST -> WT on not-taken.
        step("nt_st", 1'b1, PcA, 1'b1, 1'b0, PcA, TgtA, 1'b1, TgtA, 1'b0, TgtA, 1'b1,
             32'h0040_0014);
        look("wt", 1'b1, PcA, 1'b1, TgtA);
        step("nt_wt", 1'b1, PcA, 1'b1, 1'b0, PcA, TgtA, 1'b0, 32'h0, 1'b1, TgtA, 1'b0, 32'h0);
        look("wnt2", 1'b1, PcA, 1'b0, TgtA);
        // Aliasing branch replaces the entry.
        step("alias", 1'b1, PcA, 1'b1, 1'b1, PcB, TgtB, 1'b0, 32'h0, 1'b0, TgtA, 1'b1, TgtB);
        look("alias_a", 1'b1, PcA, 1'b0, 32'h0);
        look("alias_b", 1'b1, PcB, 1'b1, TgtB);
        // PC+4 wraps; not-taken miss writes nothing.
        step("wrap", 1'b1, PcW, 1'b1, 1'b0, PcW, 32'h0040_0000, 1'b1, 32'h0040_0000, 1'b0,
             32'h0, 1'b1, 32'h0);
        look("wrap_nw", 1'b1, PcW, 1'b0, 32'h0);
        // Mispredict pending, then reset mid-stream with the same EX inputs.
        step("pre_rst", 1'b1, PcB, 1'b1, 1'b0, PcB, TgtB, 1'b1, TgtB, 1'b0, TgtB, 1'b1,
             32'h0040_0054);
        step("mid_rst", 1'b0, PcB, 1'b1, 1'b0, PcB, TgtB, 1'b1, TgtB, 1'b0, 32'h0, 1'b0,
             32'h0);
        look("post_rst_b", 1'b1, PcB, 1'b0, 32'h0);
        look("post_rst_a", 1'b1, PcA, 1'b0, 32'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge CLK);
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
